// File: rtl/eth_pkt_pkg.sv
// Shared types and default framing constants for the Ethernet packet control FSM.
package eth_pkt_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREAMBLE = 3'd1,
      PAYLOAD  = 3'd2,
      STRIP    = 3'd3,
      DONE     = 3'd4,
      ERR      = 3'd5
   } state_e;

   localparam int         DEF_PRE_MIN   = 7;
   localparam logic [7:0] DEF_PRE_BYTE  = 8'h55;
   localparam logic [7:0] DEF_SFD_BYTE  = 8'hD5;
   localparam int         DEF_FCS_BYTES = 4;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/eth_preamble_det.sv
// Preamble run-length tracker: counts consecutive preamble bytes and flags a
// valid SFD or an aborted preamble.
module eth_preamble_det
   import eth_pkt_pkg::*;
#(
   parameter int         PRE_MIN  = DEF_PRE_MIN,
   parameter logic [7:0] PRE_BYTE = DEF_PRE_BYTE,
   parameter logic [7:0] SFD_BYTE = DEF_SFD_BYTE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_idle_i,
   input  logic       in_pre_i,
   input  logic       data_valid_i,
   input  logic [7:0] data_in_i,
   output logic       sfd_ok_o,
   output logic       pre_abort_o
);

   logic [3:0] pre_cnt_q;
   logic [3:0] pre_cnt_d;
   logic       is_pre_s;
   logic       is_sfd_s;

   assign is_pre_s = data_valid_i && (data_in_i == PRE_BYTE);
   assign is_sfd_s = data_valid_i && (data_in_i == SFD_BYTE);

   // Credit accrues only in IDLE/PREAMBLE, so bytes seen elsewhere never count.
   always_comb begin
      pre_cnt_d = 4'd0;
      if (in_idle_i && is_pre_s) begin
         pre_cnt_d = 4'd1;
      end else if (in_pre_i && is_pre_s) begin
         pre_cnt_d = sat_inc4(pre_cnt_q);
      end else begin
         pre_cnt_d = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_q <= 4'd0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

   assign sfd_ok_o    = in_pre_i && is_sfd_s && (pre_cnt_q >= 4'(PRE_MIN));
   assign pre_abort_o = in_pre_i && !sfd_ok_o && !is_pre_s;

endmodule

// File: rtl/eth_pkt_ctrl.sv
// Frame parser that drives the external byte/packet counter and reports
// good frames (FCS stripped from the length) or rejected ones.
module eth_pkt_ctrl
   import eth_pkt_pkg::*;
#(
   parameter int         PRE_MIN   = DEF_PRE_MIN,
   parameter logic [7:0] PRE_BYTE  = DEF_PRE_BYTE,
   parameter logic [7:0] SFD_BYTE  = DEF_SFD_BYTE,
   parameter int         FCS_BYTES = DEF_FCS_BYTES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_valid,
   input  logic [7:0] data_in,
   input  logic [7:0] count,
   input  logic [3:0] count0,
   output logic       load0,
   output logic       load1,
   output logic       load255,
   output logic       en,
   output logic       en_up,
   output logic       en_down,
   output logic       busy,
   output logic       pkt_done,
   output logic       pkt_err
);

   state_e     state_q;
   logic       oversize_q;
   logic       first_q;
   logic [3:0] strip_cnt_q;
   logic       sfd_ok_s;
   logic       pre_abort_s;
   logic       unused_count0_s;

   assign unused_count0_s = ^count0;

   eth_preamble_det #(
      .PRE_MIN  (PRE_MIN),
      .PRE_BYTE (PRE_BYTE),
      .SFD_BYTE (SFD_BYTE)
   ) u_pre (
      .clk          (clk),
      .reset        (reset),
      .in_idle_i    (state_q == IDLE),
      .in_pre_i     (state_q == PREAMBLE),
      .data_valid_i (data_valid),
      .data_in_i    (data_in),
      .sfd_ok_o     (sfd_ok_s),
      .pre_abort_o  (pre_abort_s)
   );

   // Frame sequencing; first_q distinguishes the first payload byte, which also
   // catches a zero-length payload whose stale count cannot be trusted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         oversize_q  <= 1'b0;
         first_q     <= 1'b0;
         strip_cnt_q <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (data_valid && (data_in == PRE_BYTE)) begin
                  state_q <= PREAMBLE;
               end else begin
                  state_q <= IDLE;
               end
            end
            PREAMBLE: begin
               if (sfd_ok_s) begin
                  state_q    <= PAYLOAD;
                  oversize_q <= 1'b0;
                  first_q    <= 1'b1;
               end else if (pre_abort_s) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= PREAMBLE;
               end
            end
            PAYLOAD: begin
               if (data_valid) begin
                  first_q <= 1'b0;
                  if (!first_q && (count == 8'hFF)) begin
                     oversize_q <= 1'b1;
                  end else begin
                     oversize_q <= oversize_q;
                  end
               end else if (oversize_q || first_q || (count <= 8'(FCS_BYTES))) begin
                  state_q <= ERR;
               end else begin
                  state_q     <= STRIP;
                  strip_cnt_q <= 4'd0;
               end
            end
            STRIP: begin
               strip_cnt_q <= strip_cnt_q + 4'd1;
               if (strip_cnt_q == 4'(FCS_BYTES - 1)) begin
                  state_q <= DONE;
               end else begin
                  state_q <= STRIP;
               end
            end
            DONE:    state_q <= IDLE;
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Counter strobes decode from the registered state; the counter acts on the next edge.
   always_comb begin
      load0    = 1'b0;
      load1    = 1'b0;
      load255  = 1'b0;
      en       = 1'b0;
      en_up    = 1'b0;
      en_down  = 1'b0;
      pkt_done = 1'b0;
      pkt_err  = 1'b0;
      if (!reset) begin
         case (state_q)
            PAYLOAD: begin
               if (!data_valid) begin
                  en_up = 1'b0;
               end else if (first_q) begin
                  load1 = 1'b1;
               end else if (count == 8'hFF) begin
                  load255 = 1'b1;
               end else begin
                  en_up = 1'b1;
               end
            end
            STRIP: en_down = 1'b1;
            DONE: begin
               en       = 1'b1;
               pkt_done = 1'b1;
            end
            ERR: begin
               load0   = 1'b1;
               pkt_err = 1'b1;
            end
            default: en = 1'b0;
         endcase
      end else begin
         en = 1'b0;
      end
   end

   assign busy = !reset && (state_q != IDLE);

endmodule

// File: tb/tb_eth_pkt_ctrl.sv
// Directed bench: eth_pkt_ctrl closed-loop with a behavioural byte/packet counter.
module tb_eth_pkt_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       data_valid;
   logic [7:0] data_in;
   logic [7:0] count;
   logic [3:0] count0;
   logic       load0, load1, load255, en, en_up, en_down;
   logic       busy, pkt_done, pkt_err;

   int total = 0;
   int bad = 0;
   int oh_bad = 0;
   int cnt [8] = '{default: 0};
   int snap [8];

   always #5 clk = ~clk;

   eth_pkt_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .data_valid (data_valid),
      .data_in    (data_in),
      .count      (count),
      .count0     (count0),
      .load0      (load0),
      .load1      (load1),
      .load255    (load255),
      .en         (en),
      .en_up      (en_up),
      .en_down    (en_down),
      .busy       (busy),
      .pkt_done   (pkt_done),
      .pkt_err    (pkt_err)
   );

   // downstream counter
   always @(posedge clk) begin
      if (reset) begin
         count  <= 8'd0;
         count0 <= 4'd0;
      end else begin
         if (load0)   count <= 8'd0;
         if (load1)   count <= 8'd1;
         if (load255) count <= 8'd255;
         if (en_up)   count <= count + 8'd1;
         if (en_down) count <= count - 8'd1;
         if (en)      count0 <= count0 + 4'd1;
      end
   end

   // strobe tallies: 0 load0, 1 load1, 2 load255, 3 en, 4 en_up, 5 en_down, 6 done, 7 err
   always @(negedge clk) begin
      if (!reset) begin
         cnt[0] += int'(load0);
         cnt[1] += int'(load1);
         cnt[2] += int'(load255);
         cnt[3] += int'(en);
         cnt[4] += int'(en_up);
         cnt[5] += int'(en_down);
         cnt[6] += int'(pkt_done);
         cnt[7] += int'(pkt_err);
         assert ($countones({load0, load1, load255, en, en_up, en_down}) <= 1) else begin
            oh_bad++;
            $error("FAIL onehot: got %0d strobes want <=1",
                   $countones({load0, load1, load255, en, en_up, en_down}));
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] b);
      @(posedge clk);
      #1;
      data_valid = v;
      data_in    = b;
   endtask

   task automatic gap(input int n);
      repeat (n) step(1'b0, 8'h00);
   endtask

   task automatic head(input int npre, input int npay);
      for (int i = 0; i < npre; i++) step(1'b1, 8'h55);
      step(1'b1, 8'hD5);
      for (int i = 0; i < npay; i++) step(1'b1, 8'(i + 160));
   endtask

   task automatic frame(input int npre, input int npay);
      head(npre, npay);
      gap(8);
   endtask

   task automatic take_snap();
      for (int k = 0; k < 8; k++) snap[k] = cnt[k];
   endtask

   function automatic int d(input int k);
      return cnt[k] - snap[k];
   endfunction

   initial begin
      reset      = 1'b1;
      data_valid = 1'b0;
      data_in    = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outs", {23'd0, load0, load1, load255, en, en_up, en_down, busy, pkt_done, pkt_err}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      gap(2);
      check("reset_busy", busy, 0);
      check("reset_count", count, 0);

      // good 64-byte frame
      take_snap();
      frame(7, 64);
      check("good_load1", d(1), 1);
      check("good_en_up", d(4), 63);
      check("good_en_down", d(5), 4);
      check("good_en", d(3), 1);
      check("good_done", d(6), 1);
      check("good_err", d(7), 0);
      check("good_count", count, 60);
      check("good_count0", count0, 1);
      check("good_busy", busy, 0);

      // short preamble
      take_snap();
      frame(5, 20);
      check("short_cmds", d(0) + d(1) + d(2) + d(3) + d(4) + d(5), 0);
      check("short_pulses", d(6) + d(7), 0);
      check("short_busy", busy, 0);
      check("short_count", count, 60);

      // runt
      take_snap();
      frame(7, 3);
      check("runt_err", d(7), 1);
      check("runt_load0", d(0), 1);
      check("runt_en_down", d(5), 0);
      check("runt_done", d(6), 0);
      check("runt_count", count, 0);
      check("runt_count0", count0, 1);

      // oversize
      take_snap();
      frame(7, 300);
      check("over_load1", d(1), 1);
      check("over_en_up", d(4), 254);
      check("over_load255", d(2), 45);
      check("over_err", d(7), 1);
      check("over_done", d(6), 0);
      check("over_count", count, 0);
      check("over_count0", count0, 1);

      // reset mid-frame
      head(7, 10);
      @(negedge clk);
      check("midrst_busy_before", busy, 1);
      @(posedge clk);
      #1;
      reset      = 1'b1;
      data_valid = 1'b0;
      @(negedge clk);
      check("midrst_forced", {pkt_done, pkt_err, busy}, 0);
      @(posedge clk);
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_count", count, 0);
      reset = 1'b0;
      check("midrst_count0", count0, 0);
      take_snap();
      frame(7, 64);
      check("midrst_good_count", count, 60);
      check("midrst_good_count0", count0, 1);
      check("midrst_pulses", d(6) * 16 + d(7), 16);

      // length boundaries
      frame(7, 5);
      check("len5_count", count, 1);
      check("len5_count0", count0, 2);
      take_snap();
      frame(7, 4);
      check("len4_err", d(7), 1);
      check("len4_count", count, 0);
      take_snap();
      frame(7, 0);
      check("len0_err", d(7), 1);
      check("len0_count0", count0, 2);

      // count0 wrap
      take_snap();
      for (int i = 0; i < 14; i++) frame(7, 10 + i);
      check("wrap_done", d(6), 14);
      check("wrap_count0", count0, 0);
      check("wrap_count", count, 19);

      // preamble byte injected during STRIP
      take_snap();
      head(7, 64);
      step(1'b0, 8'h00);
      step(1'b1, 8'h55);
      gap(8);
      check("inj_count", count, 60);
      check("inj_count0", count0, 1);
      check("inj_done", d(6), 1);
      take_snap();
      frame(6, 20);
      check("inj_six_pre_done", d(6), 0);
      check("inj_six_pre_load1", d(1), 0);
      frame(7, 8);
      check("inj_next_count", count, 4);
      check("inj_next_count0", count0, 2);

      check("onehot_total", oh_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
